// File: rtl/alu_unit_mc.sv
// Multi-cycle ALU with valid/ready handshake, registered result and condition codes.
// Build option: define ALU_MUL_EN to include the iterative shift-add multiplier (opcode 1010).
module alu_unit_mc #(
    parameter int WIDTH = 8,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             sys_clk,
    input  logic             sys_reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       alu_op,
    input  logic [WIDTH-1:0] A_bus,
    input  logic [WIDTH-1:0] B_bus,
    input  logic             alu_flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] alu_result,
    output logic             cc_greater,
    output logic             cc_equal,
    output logic             cc_carry,
    output logic             cc_overflow,
    output logic             cc_zero,
    output logic             cc_negative,
    output logic             op_illegal
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
`ifdef ALU_MUL_EN
        S_MUL  = 2'd1,
`endif
        S_DONE = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic [WIDTH-1:0] res_q;
    logic             gt_q, eq_q, c_q, v_q, z_q, n_q, ill_q;

    logic [WIDTH:0]   sum_w, diff_w;
    logic [SHW-1:0]   shamt;
    logic             sh_big, is_cmp;
    logic [WIDTH-1:0] sc_res;
    logic             sc_gt, sc_eq, sc_c, sc_v, sc_z, sc_n, sc_ill;
    logic             load_sc;

`ifdef ALU_MUL_EN
    logic               sc_is_mul, load_mul, mul_fin;
    logic [2*WIDTH-1:0] mcand_q, prod_q, mul_next;
    logic [WIDTH-1:0]   mplier_q;
    logic [SHW:0]       cnt_q;
`endif

    // Single-cycle datapath works straight off the operand buses at the accepting edge.
    always_comb begin
        sum_w  = {1'b0, A_bus} + {1'b0, B_bus};
        diff_w = {1'b0, A_bus} - {1'b0, B_bus};
        shamt  = B_bus[SHW-1:0];
        sh_big = (B_bus >> SHW) != '0;
        is_cmp = 1'b0;
        sc_res = '0;
        sc_gt  = 1'b0;
        sc_eq  = 1'b0;
        sc_c   = 1'b0;
        sc_v   = 1'b0;
        sc_ill = 1'b0;
`ifdef ALU_MUL_EN
        sc_is_mul = 1'b0;
`endif
        case (alu_op)
            4'b0000: sc_res = '0;
            4'b0001: begin
                sc_res = sum_w[WIDTH-1:0];
                sc_c   = sum_w[WIDTH];
                sc_v   = (A_bus[WIDTH-1] == B_bus[WIDTH-1]) && (sum_w[WIDTH-1] != A_bus[WIDTH-1]);
            end
            4'b0010: begin
                sc_res = diff_w[WIDTH-1:0];
                sc_c   = diff_w[WIDTH];
                sc_v   = (A_bus[WIDTH-1] != B_bus[WIDTH-1]) && (diff_w[WIDTH-1] != A_bus[WIDTH-1]);
            end
            4'b0011: sc_res = A_bus | B_bus;
            4'b0100: sc_res = A_bus & B_bus;
            4'b0101: sc_res = ~A_bus;
            4'b0110: sc_res = sh_big ? '0 : (A_bus << shamt);
            4'b0111: sc_res = sh_big ? '0 : (A_bus >> shamt);
            4'b1000: sc_res = sh_big ? {WIDTH{A_bus[WIDTH-1]}} : WIDTH'($signed(A_bus) >>> shamt);
            4'b1001: begin
                is_cmp = 1'b1;
                sc_gt  = A_bus > B_bus;
                sc_eq  = A_bus == B_bus;
            end
            4'b1011: begin
                is_cmp = 1'b1;
                sc_gt  = $signed(A_bus) > $signed(B_bus);
                sc_eq  = A_bus == B_bus;
            end
`ifdef ALU_MUL_EN
            4'b1010: sc_is_mul = 1'b1;
`endif
            default: sc_ill = 1'b1;
        endcase
        // Illegal ops must report zero=0 even though the result is 0.
        sc_z = sc_ill ? 1'b0 : (is_cmp ? sc_eq : (sc_res == '0));
        sc_n = sc_res[WIDTH-1];
    end

    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) state_q <= S_IDLE;
        else              state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        if (alu_flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (in_valid) begin
`ifdef ALU_MUL_EN
                        state_d = sc_is_mul ? S_MUL : S_DONE;
`else
                        state_d = S_DONE;
`endif
                    end
                end
`ifdef ALU_MUL_EN
                S_MUL:  if (cnt_q == (SHW+1)'(1)) state_d = S_DONE;
`endif
                S_DONE: if (out_ready) state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_comb begin
        in_ready  = (state_q == S_IDLE);
        out_valid = (state_q == S_DONE);
    end

`ifdef ALU_MUL_EN
    assign load_sc  = (state_q == S_IDLE) && in_valid && !alu_flush && !sc_is_mul;
    assign load_mul = (state_q == S_IDLE) && in_valid && !alu_flush && sc_is_mul;
    assign mul_fin  = (state_q == S_MUL) && (cnt_q == (SHW+1)'(1)) && !alu_flush;
    assign mul_next = prod_q + (mplier_q[0] ? mcand_q : '0);

    // Shift-add: multiplier consumed LSB-first, multiplicand slides left each step.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            mcand_q  <= '0;
            mplier_q <= '0;
            prod_q   <= '0;
            cnt_q    <= '0;
        end else if (load_mul) begin
            mcand_q  <= {{WIDTH{1'b0}}, A_bus};
            mplier_q <= B_bus;
            prod_q   <= '0;
            cnt_q    <= (SHW+1)'(WIDTH);
        end else if (state_q == S_MUL) begin
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            prod_q   <= mul_next;
            cnt_q    <= cnt_q - (SHW+1)'(1);
        end
    end
`else
    assign load_sc = (state_q == S_IDLE) && in_valid && !alu_flush;
`endif

    // Output registers only change on a completing op; flush leaves them untouched.
    always_ff @(posedge sys_clk or negedge sys_reset_n) begin
        if (!sys_reset_n) begin
            res_q <= '0;
            gt_q  <= 1'b0;
            eq_q  <= 1'b0;
            c_q   <= 1'b0;
            v_q   <= 1'b0;
            z_q   <= 1'b0;
            n_q   <= 1'b0;
            ill_q <= 1'b0;
        end else if (load_sc) begin
            res_q <= sc_res;
            gt_q  <= sc_gt;
            eq_q  <= sc_eq;
            c_q   <= sc_c;
            v_q   <= sc_v;
            z_q   <= sc_z;
            n_q   <= sc_n;
            ill_q <= sc_ill;
        end
`ifdef ALU_MUL_EN
        else if (mul_fin) begin
            res_q <= mul_next[WIDTH-1:0];
            gt_q  <= 1'b0;
            eq_q  <= 1'b0;
            c_q   <= |mul_next[2*WIDTH-1:WIDTH];
            v_q   <= 1'b0;
            z_q   <= (mul_next[WIDTH-1:0] == '0);
            n_q   <= mul_next[WIDTH-1];
            ill_q <= 1'b0;
        end
`endif
    end

    assign alu_result  = res_q;
    assign cc_greater  = gt_q;
    assign cc_equal    = eq_q;
    assign cc_carry    = c_q;
    assign cc_overflow = v_q;
    assign cc_zero     = z_q;
    assign cc_negative = n_q;
    assign op_illegal  = ill_q;

endmodule

// File: tb/tb_alu_unit_mc.sv
// Directed scoreboard bench for alu_unit_mc (WIDTH=8); follows ALU_MUL_EN if defined.
module tb_alu_unit_mc;

    typedef struct packed {
        logic [7:0] res;
        logic gt, eq, c, v, z, n, ill;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       in_valid = 1'b0;
    logic       in_ready;
    logic [3:0] alu_op = 4'h0;
    logic [7:0] A_bus = 8'h00;
    logic [7:0] B_bus = 8'h00;
    logic       alu_flush = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [7:0] alu_result;
    logic       cc_greater, cc_equal, cc_carry, cc_overflow, cc_zero, cc_negative, op_illegal;

    exp_t sb[$];
    int   total = 0;
    int   bad = 0;

    alu_unit_mc #(.WIDTH(8)) dut (
        .sys_clk(clk), .sys_reset_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready),
        .alu_op(alu_op), .A_bus(A_bus), .B_bus(B_bus),
        .alu_flush(alu_flush),
        .out_valid(out_valid), .out_ready(out_ready),
        .alu_result(alu_result),
        .cc_greater(cc_greater), .cc_equal(cc_equal), .cc_carry(cc_carry),
        .cc_overflow(cc_overflow), .cc_zero(cc_zero), .cc_negative(cc_negative),
        .op_illegal(op_illegal)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input logic [7:0] r, input logic gt, eq, c, v, z, n, ill);
        exp_t e;
        e.res = r; e.gt = gt; e.eq = eq; e.c = c; e.v = v; e.z = z; e.n = n; e.ill = ill;
        return e;
    endfunction

    function automatic exp_t obs();
        return mk(alu_result, cc_greater, cc_equal, cc_carry, cc_overflow, cc_zero, cc_negative, op_illegal);
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Drive one request, measure accept-to-out_valid latency, check the popped expectation, consume.
    task automatic run_op(input string tag, input logic [3:0] op, input logic [7:0] a, input logic [7:0] b,
                          input int lat, input exp_t e);
        int   n;
        exp_t ex;
        sb.push_back(e);
        @(negedge clk);
        chk({tag, ":in_ready"}, 32'(in_ready), 32'd1);
        in_valid = 1'b1; alu_op = op; A_bus = a; B_bus = b;
        @(negedge clk);
        in_valid = 1'b0;
        n = 1;
        while (!out_valid && n < 40) begin
            @(negedge clk);
            n++;
        end
        chk({tag, ":latency"}, 32'(n), 32'(lat));
        ex = (sb.size() > 0) ? sb.pop_front() : '0;
        chk({tag, ":result_flags"}, 32'(obs()), 32'(ex));
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
        chk({tag, ":consumed"}, 32'(out_valid), 32'd0);
    endtask

    initial begin
        exp_t e;
        int   seen;

        #12;
        chk("reset:flags", 32'(obs()), 32'd0);
        chk("reset:in_ready", 32'(in_ready), 32'd1);
        chk("reset:out_valid", 32'(out_valid), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        // Reset while an operation is in flight.
        @(negedge clk);
`ifdef ALU_MUL_EN
        in_valid = 1'b1; alu_op = 4'b1010; A_bus = 8'h0C; B_bus = 8'h0B;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
`else
        in_valid = 1'b1; alu_op = 4'b0001; A_bus = 8'h11; B_bus = 8'h22;
        @(negedge clk); in_valid = 1'b0;
`endif
        rst_n = 1'b0;
        #1;
        chk("midrst:flags", 32'(obs()), 32'd0);
        chk("midrst:in_ready", 32'(in_ready), 32'd1);
        chk("midrst:out_valid", 32'(out_valid), 32'd0);
        @(negedge clk) rst_n = 1'b1;

        run_op("add_5_3",   4'b0001, 8'h05, 8'h03, 1, mk(8'h08, 0, 0, 0, 0, 0, 0, 0));
        run_op("add_7f_1",  4'b0001, 8'h7F, 8'h01, 1, mk(8'h80, 0, 0, 0, 1, 0, 1, 0));
        run_op("add_ff_1",  4'b0001, 8'hFF, 8'h01, 1, mk(8'h00, 0, 0, 1, 0, 1, 0, 0));
        run_op("sub_3_5",   4'b0010, 8'h03, 8'h05, 1, mk(8'hFE, 0, 0, 1, 0, 0, 1, 0));
        run_op("sub_80_1",  4'b0010, 8'h80, 8'h01, 1, mk(8'h7F, 0, 0, 0, 1, 0, 0, 0));
`ifdef ALU_MUL_EN
        run_op("mul_0c_0b", 4'b1010, 8'h0C, 8'h0B, 9, mk(8'h84, 0, 0, 0, 0, 0, 1, 0));
        run_op("mul_20_10", 4'b1010, 8'h20, 8'h10, 9, mk(8'h00, 0, 0, 1, 0, 1, 0, 0));
`else
        run_op("mul_illeg", 4'b1010, 8'h0C, 8'h0B, 1, mk(8'h00, 0, 0, 0, 0, 0, 0, 1));
`endif
        run_op("cmp_80_01", 4'b1001, 8'h80, 8'h01, 1, mk(8'h00, 1, 0, 0, 0, 0, 0, 0));
        run_op("cmps_80_01",4'b1011, 8'h80, 8'h01, 1, mk(8'h00, 0, 0, 0, 0, 0, 0, 0));
        run_op("cmp_42_42", 4'b1001, 8'h42, 8'h42, 1, mk(8'h00, 0, 1, 0, 0, 1, 0, 0));
        run_op("lsl_01_7",  4'b0110, 8'h01, 8'h07, 1, mk(8'h80, 0, 0, 0, 0, 0, 1, 0));
        run_op("lsr_80_8",  4'b0111, 8'h80, 8'h08, 1, mk(8'h00, 0, 0, 0, 0, 1, 0, 0));
        run_op("lsr_80_3",  4'b0111, 8'h80, 8'h03, 1, mk(8'h10, 0, 0, 0, 0, 0, 0, 0));
        run_op("asr_80_10", 4'b1000, 8'h80, 8'h10, 1, mk(8'hFF, 0, 0, 0, 0, 0, 1, 0));
        run_op("asr_80_3",  4'b1000, 8'h80, 8'h03, 1, mk(8'hF0, 0, 0, 0, 0, 0, 1, 0));
        run_op("and_f0_3c", 4'b0100, 8'hF0, 8'h3C, 1, mk(8'h30, 0, 0, 0, 0, 0, 0, 0));
        run_op("not_0f",    4'b0101, 8'h0F, 8'h00, 1, mk(8'hF0, 0, 0, 0, 0, 0, 1, 0));
        run_op("nop",       4'b0000, 8'h12, 8'h34, 1, mk(8'h00, 0, 0, 0, 0, 1, 0, 0));
        run_op("illeg_1110",4'b1110, 8'h12, 8'h34, 1, mk(8'h00, 0, 0, 0, 0, 0, 0, 1));

        // Hold in DONE for 5 cycles with out_ready low.
        e = mk(8'hA5, 0, 0, 0, 0, 0, 1, 0);
        sb.push_back(e);
        @(negedge clk);
        in_valid = 1'b1; alu_op = 4'b0011; A_bus = 8'hA0; B_bus = 8'h05;
        @(negedge clk); in_valid = 1'b0;
        e = (sb.size() > 0) ? sb.pop_front() : '0;
        for (int i = 0; i < 5; i++) begin
            chk("hold:flags", 32'(obs()), 32'(e));
            chk("hold:out_valid", 32'(out_valid), 32'd1);
            chk("hold:in_ready", 32'(in_ready), 32'd0);
            @(negedge clk);
        end

        // Flush: valid drops at once, output registers keep the last value.
`ifdef ALU_MUL_EN
        out_ready = 1'b1;
        @(negedge clk); out_ready = 1'b0;
        in_valid = 1'b1; alu_op = 4'b1010; A_bus = 8'h03; B_bus = 8'h03;
        @(negedge clk); in_valid = 1'b0;
        @(negedge clk);
        alu_flush = 1'b1;
        @(negedge clk); alu_flush = 1'b0;
        chk("flush:in_ready", 32'(in_ready), 32'd1);
        chk("flush:out_valid", 32'(out_valid), 32'd0);
        chk("flush:held_flags", 32'(obs()), 32'(e));
        seen = 0;
        for (int i = 0; i < 12; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush:no_out_valid", 32'(seen), 32'd0);
`else
        alu_flush = 1'b1;
        @(negedge clk); alu_flush = 1'b0;
        chk("flush:in_ready", 32'(in_ready), 32'd1);
        chk("flush:out_valid", 32'(out_valid), 32'd0);
        chk("flush:held_flags", 32'(obs()), 32'(e));
        seen = 0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (out_valid) seen++;
        end
        chk("flush:no_out_valid", 32'(seen), 32'd0);
`endif
        run_op("post_flush_add", 4'b0001, 8'h10, 8'h20, 1, mk(8'h30, 0, 0, 0, 0, 0, 0, 0));

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
